layer_scanner: RTL and testbench

//  Read-side companion of the 64-layer counter bank: sweeps layer select 0..LAYERS-1,

---
 rtl/layer_scanner_pkg.sv | 23 ++
 rtl/layer_scanner.sv | 136 +++++++++++++
 tb/tb_layer_scanner.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : layer_scanner_pkg
// Brief   : Shared defaults and FSM state encoding for the layer scanner.
// Revision: 1.0 - initial release
// ============================================================================
package layer_scanner_pkg;

    localparam int LAYERS_DEFAULT = 64;
    localparam int SW_DEFAULT     = 6;
    localparam int DW_DEFAULT     = 8;
    localparam int TIMER_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/layer_scanner.sv
`default_nettype none
// ============================================================================
// Module  : layer_scanner
// Brief   : Sweeps the counter bank select 0..LAYERS-1 and streams
//           (layer, count) words over a valid/ready port.
//           Optional SCAN_SKIP_ZERO_EN: zero counts are not emitted.
// Revision: 1.0 - initial release
// ============================================================================
module layer_scanner
    import layer_scanner_pkg::*;
#(
    parameter int LAYERS = LAYERS_DEFAULT,
    parameter int SW     = SW_DEFAULT,
    parameter int DW     = DW_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic          c,
    input  logic          r,
    input  logic          start,
    output logic [SW-1:0] rd_s,
    input  logic [DW-1:0] rd_q,
    output logic          busy,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [SW-1:0] m_layer,
    output logic [DW-1:0] m_data,
    output logic          done
);

    localparam logic [SW-1:0]      LAST = SW'(LAYERS - 1);
    localparam logic [TIMER_W-1:0] LAT  = TIMER_W'(RD_LAT);

    state_t             state;
    state_t             state_nx;
    logic [SW-1:0]      idx;
    logic [TIMER_W-1:0] timer;

    logic sample;
    logic skip;
    logic handshake;
    logic is_last;
    logic advance;

    // rd_q is settled once RD_LAT clocks have elapsed after the select changed
    assign sample    = (state == ST_WAIT) && (timer == '0);
    assign handshake = (state == ST_OUT) && m_ready;
    assign is_last   = (idx == LAST);

`ifdef SCAN_SKIP_ZERO_EN
    assign skip = sample && (rd_q == '0);
`else
    assign skip = 1'b0;
`endif

    // Moving on to the next layer drives its select on the same edge, so the
    // address phase overlaps the handshake and each layer costs RD_LAT+2 clocks.
    assign advance = (handshake || skip) && !is_last;

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        m_valid  = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_ADDR;
                end
            end
            ST_ADDR: begin
                busy     = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (skip) begin
                    state_nx = is_last ? ST_DONE : ST_WAIT;
                end else if (sample) begin
                    state_nx = ST_OUT;
                end
            end
            ST_OUT: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nx = is_last ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            idx     <= '0;
            rd_s    <= '0;
            timer   <= '0;
            m_layer <= '0;
            m_data  <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                idx <= '0;
            end
            if (state == ST_ADDR) begin
                rd_s  <= idx;
                timer <= LAT;
            end else if (advance) begin
                idx   <= idx + 1'b1;
                rd_s  <= idx + 1'b1;
                timer <= LAT;
            end else if ((state == ST_WAIT) && (timer != '0)) begin
                timer <= timer - 1'b1;
            end
            if (sample && !skip) begin
                m_data  <= rd_q;
                m_layer <= idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_layer_scanner
// Brief   : Self-checking bench for layer_scanner: bank model with read
//           latency, queue-based expected word stream, timing literals.
// Revision: 1.0 - initial release
// ============================================================================
module tb_layer_scanner;

    localparam int LAYERS = 64;
    localparam int SW     = 6;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int PER    = RD_LAT + 2;
    localparam int L2     = 8;
    localparam int SW2    = 3;
    localparam int LAT2   = 3;

`ifdef SCAN_SKIP_ZERO_EN
    localparam int SPARSE_WORDS = 2;
    localparam int ZERO_WORDS   = 0;
`else
    localparam int SPARSE_WORDS = 64;
    localparam int ZERO_WORDS   = 64;
`endif

    logic c = 1'b0;
    logic r = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic m_ready = 1'b0;
    logic [SW-1:0]  rd_s, m_layer;
    logic [DW-1:0]  rd_q, m_data;
    logic           busy, m_valid, done;
    logic [SW2-1:0] rd_s2, m_layer2;
    logic [DW-1:0]  rd_q2, m_data2;
    logic           busy2, m_valid2, done2;

    always #5 c = ~c;

    layer_scanner #(.LAYERS(LAYERS), .SW(SW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .c(c), .r(r), .start(start), .rd_s(rd_s), .rd_q(rd_q), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_layer(m_layer), .m_data(m_data),
        .done(done)
    );

    layer_scanner #(.LAYERS(L2), .SW(SW2), .DW(DW), .RD_LAT(LAT2)) dut2 (
        .c(c), .r(r), .start(start2), .rd_s(rd_s2), .rd_q(rd_q2), .busy(busy2),
        .m_valid(m_valid2), .m_ready(1'b1), .m_layer(m_layer2), .m_data(m_data2),
        .done(done2)
    );

    // counter bank: registered read pipeline of RD_LAT stages
    logic [DW-1:0]  mem  [LAYERS];
    logic [DW-1:0]  mem2 [L2];
    logic [SW-1:0]  pipe1;
    logic [SW2-1:0] pipe2 [LAT2];

    always @(posedge c) begin
        pipe1    <= rd_s;
        pipe2[0] <= rd_s2;
        for (int i = 1; i < LAT2; i++) pipe2[i] <= pipe2[i-1];
    end
    assign rd_q  = mem[pipe1];
    assign rd_q2 = mem2[pipe2[LAT2-1]];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // model state
    logic [SW-1:0] lay_q [$];
    logic [DW-1:0] dat_q [$];
    int edge_cnt = 0;
    int e0 = 0;
    int e2 = 0;
    int rel;
    int words = 0;
    int dones = 0;
    int dones2 = 0;
    int idx2 = 0;
    bit in_sweep = 0;
    bit in2 = 0;
    bit hs_pend = 0;
    bit done_pend = 0;
    bit prev_valid = 0;
    bit timing = 0;
    bit pin5 = 0;

    always @(posedge c) begin
        edge_cnt++;
        if (!r) begin
            in_sweep = 0; in2 = 0; hs_pend = 0; done_pend = 0; prev_valid = 0;
            lay_q.delete(); dat_q.delete();
        end else begin
            if (hs_pend) begin
                void'(lay_q.pop_front());
                void'(dat_q.pop_front());
                words++;
            end
            if (start && !in_sweep) begin
                in_sweep = 1; e0 = edge_cnt; words = 0;
                for (int k = 0; k < LAYERS; k++)
`ifdef SCAN_SKIP_ZERO_EN
                    if (mem[k] != '0)
`endif
                    begin
                        lay_q.push_back(SW'(k));
                        dat_q.push_back(mem[k]);
                    end
            end else if (done_pend) begin
                in_sweep = 0;
            end
            if (start2 && !in2) begin
                in2 = 1; e2 = edge_cnt; idx2 = 0;
            end
            hs_pend = 0;
            done_pend = 0;
        end
    end

    always @(negedge c) begin
        if (r) begin
            rel = edge_cnt - e0;
            if (m_valid) begin
                if (lay_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got layer %0d data %0d expected none", m_layer, m_data);
                end else begin
                    check("m_layer", m_layer, lay_q[0]);
                    check("m_data", m_data, dat_q[0]);
                    if (pin5 && lay_q[0] == 5) check("layer5_data_lit", m_data, 8'h2A);
                    if (timing && !prev_valid) check("valid_rise_edge", rel, PER * (words + 1));
                end
            end
            if (done) begin
                check("done_in_sweep", in_sweep, 1);
                check("done_queue_empty", lay_q.size(), 0);
                if (timing) check("done_edge", rel, PER * LAYERS + 1);
                dones++;
            end
            check("busy", busy, in_sweep && !done);
            hs_pend    = m_valid && m_ready && (lay_q.size() != 0);
            done_pend  = done;
            prev_valid = m_valid;

            check("busy2", busy2, in2 && !done2);
            if (m_valid2) begin
                if (idx2 < L2) begin
                    check("m_layer2", m_layer2, idx2);
                    check("m_data2", m_data2, mem2[idx2]);
                    check("valid2_edge", edge_cnt - e2, (LAT2 + 2) * (idx2 + 1));
                end else begin
                    total++; bad++;
                    $display("FAIL extra_word2: got layer %0d expected none", m_layer2);
                end
                idx2++;
            end
            if (done2) begin
                check("done2_words", idx2, L2);
                check("done2_edge", edge_cnt - e2, (LAT2 + 2) * L2 + 1);
                dones2++;
                in2 = 0;
            end
        end
    end

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready toggles every cycle
    task automatic do_sweep(input int mode, input int exp_words, input int extra_at, input bit with2);
        int d0;
        int n;
        d0 = dones;
        start = 1'b1;
        start2 = with2;
        tick();
        start = 1'b0;
        start2 = 1'b0;
        for (n = 0; n < 4000 && dones == d0; n++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = ~m_ready;
            endcase
            start = (extra_at >= 0) && m_valid && (m_layer == SW'(extra_at));
            tick();
        end
        start = 1'b0;
        if (dones == d0) begin
            total++; bad++;
            $display("FAIL sweep_timeout: got no done expected done within 4000 cycles");
        end else if (exp_words >= 0) begin
            check("sweep_words", words, exp_words);
        end
        repeat (4) tick();
        check("single_done", dones - d0, 1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < LAYERS; k++) mem[k] = DW'(k + 1);
        for (int k = 0; k < L2; k++) mem2[k] = DW'($urandom_range(1, 255));
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_done", done, 0);
        check("rst_rd_s", rd_s, 0);
        check("rst_m_layer", m_layer, 0);
        check("rst_m_data", m_data, 0);
        r = 1'b1;
        tick();

        // ascending preload, full-rate sweep with cycle-exact timing; RD_LAT=3 instance alongside
        timing = 1;
        do_sweep(0, 64, -1, 1'b1);
        timing = 0;
        check("dut2_done_count", dones2, 1);

        // toggled back-pressure, pinned layer 5
        for (int k = 0; k < LAYERS; k++) mem[k] = DW'($urandom_range(1, 255));
        mem[5] = 8'h2A;
        pin5 = 1;
        do_sweep(2, 64, -1, 1'b0);
        pin5 = 0;

        // start re-pulsed at layer 10 must be ignored
        for (int k = 0; k < LAYERS; k++) mem[k] = DW'($urandom_range(1, 255));
        do_sweep(1, 64, 10, 1'b0);

        // asynchronous reset at layer 20, then a clean sweep
        for (int k = 0; k < LAYERS; k++) mem[k] = DW'($urandom_range(0, 255));
        start = 1'b1; tick(); start = 1'b0;
        m_ready = 1'b1;
        for (n = 0; n < 2000 && !(m_valid && m_layer == SW'(20)); n++) tick();
        check("reach_layer20", n < 2000, 1);
        #1 r = 1'b0;
        #1;
        check("async_rst_valid", m_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_s", rd_s, 0);
        check("async_rst_done", done, 0);
        tick(); tick();
        r = 1'b1;
        tick();
        do_sweep(1, -1, -1, 1'b0);

        // sparse bank, then all-zero bank
        for (int k = 0; k < LAYERS; k++) mem[k] = '0;
        mem[3] = 8'h11;
        mem[63] = 8'hFF;
        do_sweep(1, SPARSE_WORDS, -1, 1'b0);
        mem[3] = '0;
        mem[63] = '0;
        do_sweep(0, ZERO_WORDS, -1, 1'b0);

        // random banks with zeros mixed in
        repeat (2) begin
            for (int k = 0; k < LAYERS; k++)
                mem[k] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(0, 255));
            do_sweep(1, -1, -1, 1'b0);
        end

        check("dut2_single_sweep", dones2, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish before 3ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
